// File: rtl/seq_divider16by8_if.sv
// ---------------------------------------------------------------------------
// seq_divider16by8_if
// Handshake and data bundle for the sequential 16/8 divider.
//   start     : request, sampled by the divider only while idle
//   dividend  : numerator, captured when start is accepted
//   divisor   : denominator, captured when start is accepted
//   ack       : consumer has read the result, sampled only while done
//   quotient  : registered quotient
//   remainder : registered remainder
//   locked    : operands captured, divider busy or holding a result
//   done_flag : result valid, held until ack
//   div_zero  : last operation had a zero divisor
//   state     : FSM state code for the status display
// The master modport is the requesting side; the slave is the divider.
// ---------------------------------------------------------------------------
interface seq_divider16by8_if #(
    parameter int DW = 16,
    parameter int VW = 8
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          ack;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          locked;
    logic          done_flag;
    logic          div_zero;
    logic [2:0]    state;

    modport master (
        output start, dividend, divisor, ack,
        input  quotient, remainder, locked, done_flag, div_zero, state
    );

    modport slave (
        input  start, dividend, divisor, ack,
        output quotient, remainder, locked, done_flag, div_zero, state
    );
endinterface

// File: rtl/seq_divider16by8.sv
// ---------------------------------------------------------------------------
// seq_divider16by8
// Sequential restoring divider: DW-bit dividend / VW-bit divisor, one
// quotient bit per clock. A zero divisor completes immediately with an
// all-ones quotient and the low dividend byte as remainder.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset, priority over all inputs
//   bus : seq_divider16by8_if slave (start/ack handshake, operands,
//         registered results, locked/done_flag/div_zero, 3-bit state)
// ---------------------------------------------------------------------------
module seq_divider16by8 #(
    parameter int DW = 16,
    parameter int VW = 8,
    parameter int CW = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_divider16by8_if.slave    bus
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CALC = 3'd1;
    localparam logic [2:0] ST_DONE = 3'd2;

    // Last iteration index: the final quotient bit is produced when the
    // counter reads DW-1.
    localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);

    logic [2:0]    state_q,     state_d;
    logic [DW-1:0] work_q_q,    work_q_d;    // Q shift register
    logic [VW-1:0] work_d_q,    work_d_d;    // captured divisor
    logic [VW:0]   work_r_q,    work_r_d;    // partial remainder, one extra bit
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [DW-1:0] quotient_q,  quotient_d;
    logic [VW-1:0] remainder_q, remainder_d;
    logic          locked_q,    locked_d;
    logic          done_q,      done_d;
    logic          div_zero_q,  div_zero_d;

    // One restoring step. The trial subtraction is one bit wider than R so
    // its MSB is an unambiguous borrow (R shifted can reach 2*D-1).
    logic [VW:0]   shifted;
    logic [VW+1:0] trial;
    logic          fits;
    logic [DW-1:0] q_step;
    logic [VW:0]   r_step;

    always_comb begin
        shifted = {work_r_q[VW-1:0], work_q_q[DW-1]};
        trial   = {1'b0, shifted} - {2'b00, work_d_q};
        fits    = ~trial[VW+1];
        q_step  = {work_q_q[DW-2:0], fits};
        r_step  = fits ? trial[VW:0] : shifted;
    end

    always_comb begin
        state_d     = state_q;
        work_q_d    = work_q_q;
        work_d_d    = work_d_q;
        work_r_d    = work_r_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        locked_d    = locked_q;
        done_d      = done_q;
        div_zero_d  = div_zero_q;

        case (state_q)
            ST_IDLE: begin
                locked_d = 1'b0;
                done_d   = 1'b0;
                if (bus.start) begin
                    work_q_d = bus.dividend;
                    work_d_d = bus.divisor;
                    work_r_d = '0;
                    cnt_d    = '0;
                    locked_d = 1'b1;
                    if (bus.divisor == '0) begin
                        state_d     = ST_DONE;
                        quotient_d  = '1;
                        remainder_d = bus.dividend[VW-1:0];
                        div_zero_d  = 1'b1;
                        done_d      = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end

            ST_CALC: begin
                work_q_d = q_step;
                work_r_d = r_step;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d     = ST_DONE;
                    quotient_d  = q_step;
                    // Final remainder is below the divisor, so the top bit is 0.
                    remainder_d = r_step[VW-1:0];
                    div_zero_d  = 1'b0;
                    done_d      = 1'b1;
                end
            end

            ST_DONE: begin
                locked_d = 1'b1;
                done_d   = 1'b1;
                // start is deliberately ignored here, even alongside ack.
                if (bus.ack) begin
                    state_d  = ST_IDLE;
                    locked_d = 1'b0;
                    done_d   = 1'b0;
                end
            end

            default: begin
                // Unreachable codes recover to idle without touching results.
                state_d  = ST_IDLE;
                locked_d = 1'b0;
                done_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            work_q_q    <= '0;
            work_d_q    <= '0;
            work_r_q    <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            locked_q    <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q_q    <= work_q_d;
            work_d_q    <= work_d_d;
            work_r_q    <= work_r_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            locked_q    <= locked_d;
            done_q      <= done_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.locked    = locked_q;
    assign bus.done_flag = done_q;
    assign bus.div_zero  = div_zero_q;
    assign bus.state     = state_q;

endmodule

// File: doc/seq_divider16by8.md
Name: seq_divider16by8

Overview:
- Sequential restoring divider: 16-bit dividend ÷ 8-bit divisor → 16-bit quotient + 8-bit remainder, one quotient bit per clock.
- Inverse datapath of the 8-bit shift-add multiplier: accepts a 16-bit product-width operand and recovers the factors.
- Uses the same start / locked / done_flag / ack handshake and 3-bit state output (for the seven-segment status display) as the multiplier, so both can share one control panel.

Parameters:
- DW, 16, dividend and quotient width
- VW, 8, divisor and remainder width
- CW, 5, iteration counter width (must hold DW)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  request; sampled only in IDLE
- dividend  in  16  numerator; captured at accepted start
- divisor  in  8  denominator; captured at accepted start
- ack  in  1  consumer has read result; sampled only in DONE
- quotient  out  16  registered result
- remainder  out  8  registered result
- locked  out  1  operands captured, block busy (CALC or DONE)
- done_flag  out  1  result valid, held until ack
- div_zero  out  1  last operation had divisor == 0
- state  out  3  FSM state code for display

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (rst=1 at edge): state=IDLE, quotient=0, remainder=0, locked=0, done_flag=0, div_zero=0, counter=0, working registers=0. Reset mid-CALC or mid-DONE aborts with no result update. rst has priority over every other input.
- State codes: IDLE=3'd0, CALC=3'd1, DONE=3'd2. Codes 3–7 are illegal and return to IDLE on the next edge.
- All outputs are registered; none are combinational from inputs.
- IDLE:
  - locked=0, done_flag=0.
  - start=1 at edge E0 → latch dividend into the Q shift register and divisor into D; clear the 9-bit partial remainder R; counter=0; locked=1.
  - If divisor≠0: → CALC.
  - If divisor==0: → DONE directly. quotient=16'hFFFF, remainder=dividend[7:0], div_zero=1, done_flag=1, all visible after E0.
- CALC (edges E1..E16, one iteration per edge):
  - {R,Q} shifts left 1. Trial value T = {R[7:0],Q[15]} − {1'b0,D} in 9 bits.
  - If T ≥ 0: R=T, Q[0]=1. Otherwise R keeps the shifted value, Q[0]=0.
  - counter increments each edge.
  - At E16 (counter==15): quotient←final Q, remainder←final R[7:0], div_zero=0, done_flag=1, → DONE.
  - Latency: done_flag is high after exactly 16 edges following the accepting edge E0.
  - start during CALC is ignored; operands are not re-sampled.
- DONE:
  - done_flag=1, locked=1; quotient, remainder and div_zero are stable.
  - ack=1 → IDLE at the next edge: done_flag=0, locked=0.
  - quotient, remainder and div_zero hold their values until the next result is written.
  - start is ignored in DONE, including when start and ack are high in the same cycle: ack wins and start must be reasserted in IDLE.
- ack outside DONE is ignored.
- Width rules:
  - R is 9 bits so the shifted-in bit cannot overflow before compare.
  - Final remainder < divisor, so it always fits in 8 bits.
  - Quotient is a full 16 bits (divisor=1 gives quotient=dividend).
- Back-to-back operation: start held high continuously is accepted again on the first IDLE cycle after ack. Minimum period is 18 cycles (accept + 16 iterations + ack cycle).

Test Plan:
- Reset, then dividend=200, divisor=7, start pulse → done_flag rises exactly 16 cycles after the accepting edge; quotient=28, remainder=4, div_zero=0; ack → IDLE on the next edge, results held.
- dividend=65535, divisor=255 → quotient=257, remainder=0. Also dividend=1234, divisor=1 → quotient=1234, remainder=0.
- dividend=5, divisor=9 → quotient=0, remainder=5. Also dividend=0, divisor=3 → quotient=0, remainder=0.
- dividend=100, divisor=0 → done_flag=1 one cycle after accept; quotient=16'hFFFF, remainder=100, div_zero=1. The next valid operation (50/5) clears div_zero and gives quotient=10, remainder=0.
- Start 40000/13, then:
  - toggle start and change operands during CALC → result still quotient=3076, remainder=12;
  - assert start and ack together in DONE → IDLE, no new operation begins.
- Assert rst at iteration 8 → all outputs zero and state=0 next edge; a subsequent 1000/10 gives quotient=100, remainder=0.
